// File: rtl/byte_packer_if.sv
// Byte-in / word-out handshake bundle for byte_packer: upstream byte stream
// plus the downstream FIFO write port.
interface byte_packer_if #(
  parameter int D_WD = 16,
  parameter int B_WD = 8
);
  logic            i_valid;
  logic [B_WD-1:0] i_byte;
  logic            o_ready;
  logic            i_flush;
  logic            i_full;
  logic            o_write;
  logic [D_WD-1:0] o_data;

  // environment side: byte source and FIFO
  modport master (
    output i_valid, i_byte, i_flush, i_full,
    input  o_ready, o_write, o_data
  );

  // packer side
  modport slave (
    input  i_valid, i_byte, i_flush, i_full,
    output o_ready, o_write, o_data
  );
endinterface

// File: rtl/byte_packer.sv
// Packs B_WD-bit bytes LSB-first into D_WD-bit words and hands them to a FIFO,
// with zero-padded flush of partial words and a one-word holding register.
module byte_packer #(
  parameter int D_WD = 16,
  parameter int B_WD = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  byte_packer_if.slave bus,
  output logic         o_partial,
  output logic [15:0]  o_word_cnt
);
  localparam int RATIO = D_WD / B_WD;
  localparam int CW    = $clog2(RATIO);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                       state;
  logic [RATIO-1:0][B_WD-1:0]   r_acc;
  logic [RATIO-1:0][B_WD-1:0]   acc_nxt;
  logic [CW-1:0]                r_cnt;
  logic [D_WD-1:0]              r_word;
  logic                         accept;
  logic                         flush_ok;
  logic                         complete;
  logic                         do_flush;
  logic                         load;

  assign bus.o_ready = ~i_rst & ((state == FILL) | ~bus.i_full);
  assign bus.o_write = ~i_rst & (state == HOLD) & ~bus.i_full;
  assign bus.o_data  = r_word;
  assign o_partial   = (r_cnt != '0);

  assign accept   = bus.i_valid & bus.o_ready;
  assign flush_ok = bus.i_flush & bus.o_ready;
  assign complete = accept & (r_cnt == CW'(RATIO-1));
  assign do_flush = flush_ok & ~complete & (accept | (r_cnt != '0));
  assign load     = complete | do_flush;

  // Slots at and above r_cnt are always zero (r_acc is cleared on every load),
  // so acc_nxt is already zero-padded when a flush closes a partial word.
  for (genvar s = 0; s < RATIO; s++) begin : g_slot
    assign acc_nxt[s] = (accept && (r_cnt == CW'(s))) ? bus.i_byte : r_acc[s];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= FILL;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_word     <= '0;
      o_word_cnt <= '0;
    end else begin
      if (bus.o_write) o_word_cnt <= o_word_cnt + 16'd1;
      if (load) begin
        // a new word may replace the one being written this same cycle
        r_word <= acc_nxt;
        r_acc  <= '0;
        r_cnt  <= '0;
        state  <= HOLD;
      end else begin
        if (accept) begin
          r_acc <= acc_nxt;
          r_cnt <= r_cnt + CW'(1);
        end
        if (bus.o_write) state <= FILL;
      end
    end
  end
endmodule

// File: tb/tb_byte_packer.sv
// Self-checking bench for byte_packer (16/8): directed vector table, reset
// sequences, then random traffic against a queue-based reference model.
module tb_byte_packer;
  localparam int D_WD  = 16;
  localparam int B_WD  = 8;
  localparam int RATIO = D_WD / B_WD;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        o_partial;
  logic [15:0] o_word_cnt;

  byte_packer_if #(.D_WD(D_WD), .B_WD(B_WD)) bus ();

  byte_packer #(.D_WD(D_WD), .B_WD(B_WD)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .bus        (bus),
    .o_partial  (o_partial),
    .o_word_cnt (o_word_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic        fl;
    logic        full;
    logic        rdy;
    logic        wr;
    logic        part;
    logic [15:0] data;
    logic [15:0] cnt;
  } vec_t;

  vec_t tv[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic add(input logic v, input logic [7:0] b, input logic fl, input logic full,
                     input logic rdy, input logic wr, input logic part,
                     input logic [15:0] data, input logic [15:0] cnt);
    vec_t t;
    t.v = v; t.b = b; t.fl = fl; t.full = full;
    t.rdy = rdy; t.wr = wr; t.part = part; t.data = data; t.cnt = cnt;
    tv.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  task automatic drive(input logic v, input logic [7:0] b, input logic fl, input logic full);
    bus.i_valid = v;
    bus.i_byte  = b;
    bus.i_flush = fl;
    bus.i_full  = full;
  endtask

  // reference model state
  logic [7:0]  q[$];
  logic        held;
  logic [15:0] last_word;
  logic [15:0] cnt_m;

  function automatic logic [15:0] pack_q();
    logic [15:0] w;
    w = '0;
    foreach (q[i]) w[i*B_WD +: B_WD] = q[i];
    return w;
  endfunction

  initial begin
    logic v, fl, full, e_rdy, e_wr;
    logic [7:0] b;

    i_rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge i_clk);

    // reset state
    #1;
    chk("rst_ready", 32'(bus.o_ready), 32'(1'b0));
    chk("rst_write", 32'(bus.o_write), 32'(1'b0));
    chk("rst_data",  32'(bus.o_data),  32'h0);
    chk("rst_cnt",   32'(o_word_cnt),  32'h0);
    chk("rst_part",  32'(o_partial),   32'(1'b0));
    @(negedge i_clk);
    i_rst = 1'b0;

    // directed table: inputs for the cycle, outputs expected before its edge
    add(1'b1,8'h11,1'b0,1'b0, 1'b1,1'b0,1'b0,16'h0000,16'd0);
    add(1'b1,8'h22,1'b0,1'b0, 1'b1,1'b0,1'b1,16'h0000,16'd0);
    add(1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,1'b0,16'h2211,16'd0);
    add(1'b1,8'hA1,1'b0,1'b0, 1'b1,1'b0,1'b0,16'h2211,16'd1);
    add(1'b1,8'hA2,1'b0,1'b0, 1'b1,1'b0,1'b1,16'h2211,16'd1);
    add(1'b1,8'hA3,1'b0,1'b0, 1'b1,1'b1,1'b0,16'hA2A1,16'd1);
    add(1'b1,8'hA4,1'b0,1'b0, 1'b1,1'b0,1'b1,16'hA2A1,16'd2);
    add(1'b1,8'hA5,1'b0,1'b0, 1'b1,1'b1,1'b0,16'hA4A3,16'd2);
    add(1'b1,8'hA6,1'b0,1'b0, 1'b1,1'b0,1'b1,16'hA4A3,16'd3);
    add(1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,1'b0,16'hA6A5,16'd3);
    add(1'b1,8'h44,1'b0,1'b1, 1'b1,1'b0,1'b0,16'hA6A5,16'd4);
    add(1'b1,8'h33,1'b0,1'b1, 1'b1,1'b0,1'b1,16'hA6A5,16'd4);
    add(1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,1'b0,16'h3344,16'd4);
    add(1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,1'b0,16'h3344,16'd4);
    add(1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,1'b0,16'h3344,16'd4);
    add(1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,1'b0,16'h3344,16'd4);
    add(1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,1'b0,16'h3344,16'd5);
    add(1'b1,8'h5A,1'b0,1'b0, 1'b1,1'b0,1'b0,16'h3344,16'd5);
    add(1'b0,8'h00,1'b1,1'b0, 1'b1,1'b0,1'b1,16'h3344,16'd5);
    add(1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,1'b0,16'h005A,16'd5);
    add(1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,1'b0,16'h005A,16'd6);
    add(1'b0,8'h00,1'b1,1'b0, 1'b1,1'b0,1'b0,16'h005A,16'd6);
    add(1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,1'b0,16'h005A,16'd6);
    add(1'b1,8'h01,1'b0,1'b1, 1'b1,1'b0,1'b0,16'h005A,16'd6);
    add(1'b1,8'h02,1'b0,1'b1, 1'b1,1'b0,1'b1,16'h005A,16'd6);
    add(1'b0,8'h00,1'b1,1'b1, 1'b0,1'b0,1'b0,16'h0201,16'd6);
    add(1'b1,8'h99,1'b1,1'b1, 1'b0,1'b0,1'b0,16'h0201,16'd6);
    add(1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,1'b0,16'h0201,16'd6);
    add(1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,1'b0,16'h0201,16'd7);
    add(1'b1,8'h10,1'b0,1'b0, 1'b1,1'b0,1'b0,16'h0201,16'd7);
    add(1'b1,8'h20,1'b1,1'b0, 1'b1,1'b0,1'b1,16'h0201,16'd7);
    add(1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,1'b0,16'h2010,16'd7);
    add(1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,1'b0,16'h2010,16'd8);
    add(1'b1,8'h30,1'b1,1'b0, 1'b1,1'b0,1'b0,16'h2010,16'd8);
    add(1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,1'b0,16'h0030,16'd8);
    add(1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,1'b0,16'h0030,16'd9);

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].v, tv[i].b, tv[i].fl, tv[i].full);
      #1;
      chk($sformatf("tv%0d_ready", i), 32'(bus.o_ready), 32'(tv[i].rdy));
      chk($sformatf("tv%0d_write", i), 32'(bus.o_write), 32'(tv[i].wr));
      chk($sformatf("tv%0d_part",  i), 32'(o_partial),   32'(tv[i].part));
      chk($sformatf("tv%0d_data",  i), 32'(bus.o_data),  32'(tv[i].data));
      chk($sformatf("tv%0d_cnt",   i), 32'(o_word_cnt),  32'(tv[i].cnt));
      @(negedge i_clk);
    end

    // reset after a lone 0x77: it must be discarded
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    #1 chk("r77_ready", 32'(bus.o_ready), 32'(1'b1));
    @(negedge i_clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    i_rst = 1'b1;
    #1;
    chk("r77_rst_ready", 32'(bus.o_ready), 32'(1'b0));
    chk("r77_rst_part",  32'(o_partial),   32'(1'b1));
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("r77_post_part", 32'(o_partial),  32'(1'b0));
    chk("r77_post_data", 32'(bus.o_data), 32'h0);
    chk("r77_post_cnt",  32'(o_word_cnt), 32'h0);
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    @(negedge i_clk);
    drive(1'b1, 8'h02, 1'b0, 1'b0);
    @(negedge i_clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("r77_write", 32'(bus.o_write), 32'(1'b1));
    chk("r77_data",  32'(bus.o_data),  32'h0201);
    @(negedge i_clk);
    #1;
    chk("r77_cnt",    32'(o_word_cnt),  32'd1);
    chk("r77_nowr",   32'(bus.o_write), 32'(1'b0));

    // reset while a word is held and the FIFO has room: no write escapes
    drive(1'b1, 8'h03, 1'b0, 1'b0);
    @(negedge i_clk);
    drive(1'b1, 8'h04, 1'b0, 1'b0);
    @(negedge i_clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    i_rst = 1'b1;
    #1;
    chk("hrst_write", 32'(bus.o_write), 32'(1'b0));
    chk("hrst_ready", 32'(bus.o_ready), 32'(1'b0));
    chk("hrst_data",  32'(bus.o_data),  32'h0403);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("hrst_post_write", 32'(bus.o_write), 32'(1'b0));
    chk("hrst_post_data",  32'(bus.o_data),  32'h0);
    chk("hrst_post_cnt",   32'(o_word_cnt),  32'h0);

    // random traffic against the queue model, starting from the reset state
    q.delete();
    held = 1'b0; last_word = '0; cnt_m = '0;
    for (int c = 0; c < 3000; c++) begin
      v    = ($urandom_range(0, 3) != 0);
      b    = 8'($urandom);
      fl   = ($urandom_range(0, 7) == 0);
      full = ($urandom_range(0, 3) == 0);
      drive(v, b, fl, full);
      #1;
      e_rdy = !held || !full;
      e_wr  = held && !full;
      chk("rnd_ready", 32'(bus.o_ready), 32'(e_rdy));
      chk("rnd_write", 32'(bus.o_write), 32'(e_wr));
      chk("rnd_data",  32'(bus.o_data),  32'(last_word));
      chk("rnd_part",  32'(o_partial),   32'(q.size() != 0));
      chk("rnd_cnt",   32'(o_word_cnt),  32'(cnt_m));
      if (e_wr) begin
        held  = 1'b0;
        cnt_m = cnt_m + 16'd1;
      end
      if (v && e_rdy) q.push_back(b);
      if (q.size() == RATIO || (fl && e_rdy && q.size() > 0)) begin
        last_word = pack_q();
        q.delete();
        held = 1'b1;
      end
      @(negedge i_clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
